// File: rtl/systolic_feeder.sv
// Feeds an NxN systolic array: pairs A/B beat vectors, zero-fills bubbles and
// skews each lane by its index so operands meet at the right PE on the right cycle.
module systolic_feeder #(
   parameter int N     = 32,
   parameter int W     = 16,
   parameter int KW    = 8,
   parameter int DRAIN = 2 * N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KW-1:0]    k_len,
   input  logic             a_valid,
   input  logic [N*W-1:0]   a_vec,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [N*W-1:0]   b_vec,
   output logic             b_ready,
   output logic [N*W-1:0]   A_west,
   output logic [N*W-1:0]   B_north,
   output logic             acc_clr,
   output logic             busy,
   output logic             done
);

   localparam int FW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      FLUSH,
      DONE
   } state_t;

   state_t          state;
   logic [KW-1:0]   beat_cnt;
   logic [FW-1:0]   flush_cnt;
   logic            xfer;
   logic [N*W-1:0]  a_inj;
   logic [N*W-1:0]  b_inj;

   // Both vectors move together: each side's ready waits on the other's valid.
   assign a_ready = (state == FEED) & b_valid;
   assign b_ready = (state == FEED) & a_valid;
   assign xfer    = (state == FEED) & a_valid & b_valid;
   assign busy    = (state != IDLE);

   assign a_inj = xfer ? a_vec : '0;
   assign b_inj = xfer ? b_vec : '0;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         flush_cnt <= '0;
         acc_clr   <= 1'b0;
         done      <= 1'b0;
      end else begin
         acc_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  beat_cnt <= k_len;
                  acc_clr  <= 1'b1;
                  if (k_len == '0) begin
                     state     <= FLUSH;
                     flush_cnt <= FW'(1);
                  end else begin
                     state <= FEED;
                  end
               end
            end
            FEED: begin
               if (xfer) begin
                  beat_cnt <= beat_cnt - KW'(1);
                  if (beat_cnt == KW'(1)) begin
                     state     <= FLUSH;
                     flush_cnt <= FW'(1);
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt == FW'(DRAIN)) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  flush_cnt <= '0;
               end else begin
                  flush_cnt <= flush_cnt + FW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Lane i is delayed by i+1 registers; the chains shift every cycle so
   // zero bubbles propagate exactly like data.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [W-1:0] a_pipe [0:i];
      logic [W-1:0] b_pipe [0:i];

      // NOTE: the skew registers are reset so an aborted pass cannot leak
      // stale operands into the array after reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= i; s++) begin
               a_pipe[s] <= '0;
               b_pipe[s] <= '0;
            end
         end else begin
            a_pipe[0] <= a_inj[i*W +: W];
            b_pipe[0] <= b_inj[i*W +: W];
            for (int s = 1; s <= i; s++) begin
               a_pipe[s] <= a_pipe[s-1];
               b_pipe[s] <= b_pipe[s-1];
            end
         end
      end

      assign A_west[i*W +: W]  = a_pipe[i];
      assign B_north[i*W +: W] = b_pipe[i];
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The module SHALL have parameter N, default 32, meaning array dimension and lane count.
REQ-002 The module SHALL have parameter W, default 16, meaning element width.
REQ-003 The module SHALL have parameter KW, default 8, meaning width of the inner-dimension length field.
REQ-004 The module SHALL have parameter DRAIN, default 2*N, meaning FLUSH cycles after the last beat.
REQ-005 The module SHALL have port clk  input  1  clock; one clock, all logic on its rising edge.
REQ-006 The module SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 The module SHALL have port start  input  1  one-cycle request to begin a matrix pass.
REQ-008 The module SHALL have port k_len  input  KW  inner-dimension length, sampled when start is accepted.
REQ-009 The module SHALL have port a_valid  input  1  a_vec holds element k of every A row.
REQ-010 The module SHALL have port a_vec  input  N*W  lane i at bits [i*W +: W].
REQ-011 The module SHALL have port a_ready  output  1  feeder accepts a_vec.
REQ-012 The module SHALL have port b_valid  input  1  b_vec holds row k of B.
REQ-013 The module SHALL have port b_vec  input  N*W  lane j at bits [j*W +: W].
REQ-014 The module SHALL have port b_ready  output  1  feeder accepts b_vec.
REQ-015 The module SHALL have port A_west  output  N*W  skewed west-edge row data to the array.
REQ-016 The module SHALL have port B_north  output  N*W  skewed north-edge column data to the array.
REQ-017 The module SHALL have port acc_clr  output  1  one-cycle pulse that clears the array accumulators.
REQ-018 The module SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 The module SHALL have port done  output  1  one-cycle pulse when all products have reached PE[N-1][N-1].

Function
REQ-020 The FSM SHALL have states IDLE, FEED, FLUSH and DONE.
REQ-021 IDLE SHALL go to FEED on start when k_len>0, and to FLUSH on start when k_len==0; in both cases it latches k_len into a beat counter and pulses acc_clr the following cycle.
REQ-022 A start received in any state other than IDLE SHALL be ignored, with no change to the counter or to k_len.
REQ-023 a_ready SHALL equal (state==FEED & b_valid), and b_ready SHALL equal (state==FEED & a_valid).
REQ-024 A beat SHALL transfer only when a_valid & b_valid & state==FEED, so both vectors are always consumed together.
REQ-025 Every transfer SHALL decrement the beat counter; the transfer that brings it to 0 SHALL move the FSM to FLUSH on the next cycle.
REQ-026 The inject vector SHALL equal a_vec/b_vec on a transfer cycle and all-zero otherwise, covering FEED stalls, FLUSH and IDLE; zero bubbles add nothing to the MACs.
REQ-027 Skew: lane i of A_west SHALL present the inject value from cycle t-1-i at cycle t, implemented as a registered chain of depth i+1.
REQ-028 B_north lane j SHALL use the same skew as A_west, with depth j+1.
REQ-029 The skew chains SHALL shift every cycle, independent of handshake state.
REQ-030 In FLUSH, a counter SHALL run from 1 to DRAIN; at DRAIN the FSM SHALL go to DONE.
REQ-031 In DONE, done=1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-032 busy SHALL equal (state!=IDLE), and done SHALL never coincide with acc_clr.
REQ-033 A start that arrives in the same cycle as the done pulse SHALL be ignored; a start one cycle after the done pulse SHALL be accepted.
REQ-034 k_len at its maximum (2^KW-1) SHALL NOT wrap the beat counter.

Reset
REQ-035 While rst=1 at a clock edge, state SHALL become IDLE and all counters SHALL clear to 0.
REQ-036 While rst=1 at a clock edge, every skew register SHALL clear to 0, so A_west=B_north=0.
REQ-037 While rst=1 at a clock edge, the outputs SHALL take the values a_ready=b_ready=acc_clr=busy=done=0.
REQ-038 A reset asserted mid-FEED or mid-FLUSH SHALL abort the pass with no done pulse, and in-flight skewed data SHALL be discarded.

Verification
REQ-039 With N=4, start, k_len=3 and a/b valid every cycle with lane value = 10*k+lane, the bench SHALL check acc_clr at cycle 1, A_west[i] at cycle t equal to beat (t-2-i) or 0, and done exactly 3+DRAIN+1 cycles after FEED entry.
REQ-040 With b_valid low for 2 cycles mid-FEED, the bench SHALL check a_ready=0, no transfer, zeros injected on those cycles, and the pass completing with exactly 3 transfers.
REQ-041 With start at k_len=0, the bench SHALL check no ready assertion, A_west/B_north staying 0, and done after DRAIN+1 cycles.
REQ-042 With a second start during FEED, the bench SHALL check that it is ignored and that the beat count is unchanged.
REQ-043 With rst asserted during FLUSH, the bench SHALL check all outputs at 0 the next cycle, no done pulse, and that a new start is accepted afterwards.
REQ-044 With back-to-back passes (start one cycle after done), the bench SHALL check that the second acc_clr pulse is distinct from the done pulse and that the data does not overlap.
